// File: rtl/poll_frame_scheduler.sv
// poll_frame_scheduler: round-robin poller of NCH half-duplex links over one shared transaction slot,
// with response timeout and per-channel health status (error counts, miss tracking, no-response flag).
module poll_frame_scheduler #(
  parameter int NCH        = 4,
  parameter int CW         = 2,
  parameter int TO_CYC     = 100000,
  parameter int MISS_LIMIT = 3,
  parameter int GAP_CYC    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   chan_en,
  input  logic [NCH-1:0]   tx_busy,
  input  logic [NCH-1:0]   rx_frame_done,
  input  logic [NCH-1:0]   check_sum_error,
  input  logic             clr_status,
  output logic [NCH-1:0]   tx_start,
  output logic [CW-1:0]    chan_sel,
  output logic             active,
  output logic [NCH-1:0]   com_no_response,
  output logic [NCH*8-1:0] err_cnt,
  output logic             timeout_pulse
);
  localparam int TW = $clog2(TO_CYC + GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, START, TX, RESP, GAP} state_t;
  state_t         state, nxt;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  rr_ptr, pick;
  logic           found, seen_busy, busy_sel, win, ev_ok, ev_err, expire;
  logic [3:0]     miss_cnt [NCH];
  logic [3:0]     miss_nxt;
  logic [7:0]     err_q [NCH];
  // Scanning from the highest offset down leaves the nearest enabled channel after rr_ptr in pick.
  always_comb begin
    int j;
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NCH) j = j - NCH;
      if (chan_en[j]) begin
        found = 1'b1;
        pick  = CW'(j);
      end
    end
  end
  assign win      = (state == TX) || (state == RESP);
  assign busy_sel = tx_busy[chan_sel];
  assign ev_err   = win && check_sum_error[chan_sel];
  assign ev_ok    = win && rx_frame_done[chan_sel] && !check_sum_error[chan_sel];
  assign active   = (state == START) || win;
  assign expire   = active && (timer == TW'(TO_CYC - 1)) && !ev_err && !ev_ok;
  assign tx_start = (state == START) ? (NCH'(1) << chan_sel) : '0;
  assign miss_nxt = (miss_cnt[chan_sel] == 4'(MISS_LIMIT)) ? miss_cnt[chan_sel] : miss_cnt[chan_sel] + 4'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = found ? START : IDLE;
      START:   nxt = expire ? GAP : TX;
      TX:      nxt = (ev_ok || ev_err || expire) ? GAP : (seen_busy && !busy_sel) ? RESP : TX;
      RESP:    nxt = (ev_ok || ev_err || expire) ? GAP : RESP;
      GAP:     nxt = (timer == TW'(GAP_CYC - 1)) ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      timer           <= '0;
      rr_ptr          <= '0;
      chan_sel        <= '0;
      seen_busy       <= 1'b0;
      timeout_pulse   <= 1'b0;
      com_no_response <= '0;
      for (int i = 0; i < NCH; i++) begin
        miss_cnt[i] <= '0;
        err_q[i]    <= '0;
      end
    end else begin
      state         <= nxt;
      timer         <= (state == IDLE || (nxt == GAP && state != GAP)) ? '0 : timer + TW'(1);
      seen_busy     <= (state == START) ? 1'b0 : seen_busy | ((state == TX) && busy_sel);
      timeout_pulse <= expire;
      if (state == IDLE && found) chan_sel <= pick;
      if (state == GAP && nxt == IDLE) rr_ptr <= (chan_sel == CW'(NCH - 1)) ? '0 : chan_sel + 1'b1;
      if (clr_status) begin
        com_no_response <= '0;
        for (int i = 0; i < NCH; i++) begin
          miss_cnt[i] <= '0;
          err_q[i]    <= '0;
        end
      end else if (ev_ok) begin
        miss_cnt[chan_sel]        <= '0;
        com_no_response[chan_sel] <= 1'b0;
      end else if (ev_err || expire) begin
        miss_cnt[chan_sel] <= miss_nxt;
        if (miss_nxt == 4'(MISS_LIMIT)) com_no_response[chan_sel] <= 1'b1;
        if (ev_err && err_q[chan_sel] != 8'hff) err_q[chan_sel] <= err_q[chan_sel] + 8'd1;
      end
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_err
    assign err_cnt[8*g +: 8] = err_q[g];
  end
endmodule
